// File: rtl/bp_reg_bank_pkg.sv
// Shared types and field positions for the byte-pipe register bank.
// Command byte is {wr, addr}; length byte is {incr, len}.
package bp_reg_bank_pkg;
   localparam int ADDR_W   = 7;
   localparam int LEN_W    = 7;
   localparam int CMD_WR   = 7;
   localparam int LEN_INCR = 7;

   typedef enum logic [1:0] {
      ST_CMD,
      ST_LEN,
      ST_WRITE,
      ST_READ
   } state_t;
endpackage

// File: rtl/bp_reg_bank_regs.sv
// Register array with read-only masking, per-register write strobes
// and a read mux that returns zero for addresses beyond the bank.
module bp_reg_bank_regs
   import bp_reg_bank_pkg::*;
#(
   parameter int               N_REG   = 63,
   parameter logic [7:0]       VALUE0  = 8'h00,
   parameter logic [N_REG-1:0] RO_MASK = '0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [7:0]         wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [7:0]         rdata_o,
   output logic [8*N_REG-1:0] regs_o,
   output logic [N_REG-1:0]   strobe_o
);
   // Register 0 is the ID register and can never be written.
   localparam logic [N_REG-1:0] RO_EFF = RO_MASK | N_REG'(1);

   genvar gi;
   for (gi = 0; gi < N_REG; gi++) begin : g_reg
      if (RO_EFF[gi]) begin : g_ro
         assign regs_o[8*gi +: 8] = (gi == 0) ? VALUE0 : 8'h00;
         assign strobe_o[gi]      = 1'b0;
      end else begin : g_rw
         logic       hit;
         logic [7:0] val_q;
         logic       stb_q;

         assign hit = we_i && (waddr_i == ADDR_W'(gi));

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               val_q <= 8'h00;
               stb_q <= 1'b0;
            end else begin
               stb_q <= hit;
               if (hit) begin
                  val_q <= wdata_i;
               end
            end
         end

         assign regs_o[8*gi +: 8] = val_q;
         assign strobe_o[gi]      = stb_q;
      end
   end

   always_comb begin
      rdata_o = 8'h00;
      for (int a = 0; a < N_REG; a++) begin
         if (raddr_i == ADDR_W'(a)) begin
            rdata_o = regs_o[8*a +: 8];
         end
      end
   end
endmodule

// File: rtl/bp_reg_bank.sv
// Byte-pipe burst register bank: command/length framing FSM, address and
// count counters, and the registered bank-to-host output byte.
module bp_reg_bank
   import bp_reg_bank_pkg::*;
#(
   parameter int               N_REG   = 63,
   parameter logic [7:0]       VALUE0  = 8'h00,
   parameter logic [N_REG-1:0] RO_MASK = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cg,
   input  logic [7:0]         i_bp_data,
   input  logic               i_bp_valid,
   output logic               o_bp_ready,
   output logic [7:0]         o_bp_data,
   output logic               o_bp_valid,
   input  logic               i_bp_ready,
   output logic [8*N_REG-1:0] o_regs,
   output logic [N_REG-1:0]   o_wrStrobe
);
   state_t            state_q;
   logic              wr_q;
   logic              incr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] raddr;
   logic [LEN_W:0]    cnt_q;
   logic [7:0]        data_q;
   logic              valid_q;
   logic [7:0]        rdata;
   logic              in_acc;
   logic              out_acc;
   logic              we;

   assign o_bp_ready = (state_q != ST_READ);
   assign o_bp_data  = data_q;
   assign o_bp_valid = valid_q;

   assign in_acc  = i_cg & i_bp_valid & o_bp_ready;
   assign out_acc = i_cg & valid_q & i_bp_ready;
   assign addr_d  = addr_q + ADDR_W'(incr_q);
   assign we      = in_acc && (state_q == ST_WRITE);
   // During a read the mux looks one address ahead so the next byte is ready on accept.
   assign raddr   = (state_q == ST_READ) ? addr_d : addr_q;

   bp_reg_bank_regs #(
      .N_REG   (N_REG),
      .VALUE0  (VALUE0),
      .RO_MASK (RO_MASK)
   ) u_regs (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .we_i     (we),
      .waddr_i  (addr_q),
      .wdata_i  (i_bp_data),
      .raddr_i  (raddr),
      .rdata_o  (rdata),
      .regs_o   (o_regs),
      .strobe_o (o_wrStrobe)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_CMD;
         wr_q    <= 1'b0;
         incr_q  <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else if (i_cg) begin
         case (state_q)
            ST_CMD: begin
               if (in_acc) begin
                  wr_q    <= i_bp_data[CMD_WR];
                  addr_q  <= i_bp_data[ADDR_W-1:0];
                  state_q <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (in_acc) begin
                  incr_q <= i_bp_data[LEN_INCR];
                  // A length of zero encodes a full 128-byte burst.
                  cnt_q  <= (i_bp_data[LEN_W-1:0] == '0) ? (LEN_W+1)'(1 << LEN_W)
                                                         : {1'b0, i_bp_data[LEN_W-1:0]};
                  if (wr_q) begin
                     state_q <= ST_WRITE;
                  end else begin
                     state_q <= ST_READ;
                     data_q  <= rdata;
                     valid_q <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (in_acc) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q - (LEN_W+1)'(1);
                  if (cnt_q == (LEN_W+1)'(1)) begin
                     state_q <= ST_CMD;
                  end
               end
            end
            ST_READ: begin
               if (out_acc) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q - (LEN_W+1)'(1);
                  if (cnt_q == (LEN_W+1)'(1)) begin
                     valid_q <= 1'b0;
                     state_q <= ST_CMD;
                  end else begin
                     data_q <= rdata;
                  end
               end
            end
            default: state_q <= ST_CMD;
         endcase
      end
   end
endmodule

// File: tb/tb_bp_reg_bank.sv
// Directed and randomized bursts against a plain array model of the bank.
module tb_bp_reg_bank;
   localparam int         N    = 6;
   localparam logic [7:0] VAL0 = 8'h5A;
   localparam logic [N-1:0] RO = 6'b010000;

   logic           i_clk = 1'b0;
   logic           i_rst;
   logic           i_cg;
   logic [7:0]     i_bp_data;
   logic           i_bp_valid;
   logic           o_bp_ready;
   logic [7:0]     o_bp_data;
   logic           o_bp_valid;
   logic           i_bp_ready;
   logic [8*N-1:0] o_regs;
   logic [N-1:0]   o_wrStrobe;

   int total = 0;
   int bad   = 0;
   logic [7:0] m [128];

   bp_reg_bank #(.N_REG(N), .VALUE0(VAL0), .RO_MASK(RO)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_cg       (i_cg),
      .i_bp_data  (i_bp_data),
      .i_bp_valid (i_bp_valid),
      .o_bp_ready (o_bp_ready),
      .o_bp_data  (o_bp_data),
      .o_bp_valid (o_bp_valid),
      .i_bp_ready (i_bp_ready),
      .o_regs     (o_regs),
      .o_wrStrobe (o_wrStrobe)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit is_ro(input int a);
      return (a == 0) || RO[a];
   endfunction

   function automatic logic [7:0] mread(input int a);
      return (a < N) ? m[a] : 8'h00;
   endfunction

   function automatic logic [8*N-1:0] flat();
      logic [8*N-1:0] f;
      for (int a = 0; a < N; a++) f[8*a +: 8] = m[a];
      return f;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 128; a++) m[a] = 8'h00;
      m[0] = VAL0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Presents one host byte; returns 1ns after the accepting edge.
   task automatic push(input logic [7:0] b);
      i_bp_data  = b;
      i_bp_valid = 1'b1;
      @(negedge i_clk);
      check("bp_ready", o_bp_ready, 1);
      @(posedge i_clk); #1;
      i_bp_valid = 1'b0;
   endtask

   task automatic wr_burst(input int a, input bit inc, input logic [7:0] d[$]);
      int cur = a;
      logic [N-1:0] stb;
      push({1'b1, 7'(a)});
      push({inc, 7'(d.size() % 128)});
      foreach (d[k]) begin
         push(d[k]);
         stb = '0;
         if (cur < N && !is_ro(cur)) begin
            m[cur]   = d[k];
            stb[cur] = 1'b1;
         end
         check("wr_strobe", o_wrStrobe, stb);
         check("wr_regs", o_regs, flat());
         cur = (cur + int'(inc)) % 128;
      end
      @(posedge i_clk); #1;
      check("wr_strobe_clear", o_wrStrobe, 0);
      $display("txn write addr=%0d incr=%0d n=%0d", a, inc, d.size());
   endtask

   task automatic rd_burst(input int a, input bit inc, input int n, input bit bp);
      int cur   = a;
      int k     = 0;
      int stall = 0;
      push({1'b0, 7'(a)});
      push({inc, 7'(n % 128)});
      while (k < n) begin
         i_bp_ready = bp ? (($urandom_range(0, 1) == 1) || stall >= 3) : 1'b1;
         @(negedge i_clk);
         check("rd_valid", o_bp_valid, 1);
         check("rd_data", o_bp_data, mread(cur));
         if (k == 0 && stall == 0) check("rd_ready_low", o_bp_ready, 0);
         @(posedge i_clk); #1;
         if (i_bp_ready) begin
            k++;
            cur   = (cur + int'(inc)) % 128;
            stall = 0;
         end else begin
            stall++;
         end
      end
      i_bp_ready = 1'b0;
      @(negedge i_clk);
      check("rd_end_valid", o_bp_valid, 0);
      check("rd_end_ready", o_bp_ready, 1);
      @(posedge i_clk); #1;
      $display("txn read addr=%0d incr=%0d n=%0d", a, inc, n);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] e0, e1;

      i_rst = 1'b1; i_cg = 1'b1; i_bp_data = 8'h00; i_bp_valid = 1'b0; i_bp_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_ready", o_bp_ready, 1);
      check("rst_valid", o_bp_valid, 0);
      check("rst_data", o_bp_data, 8'h00);
      check("rst_strobe", o_wrStrobe, 0);
      check("rst_regs", o_regs, flat());
      @(posedge i_clk); #1;
      $display("txn reset");

      // ID register readback
      rd_burst(0, 1'b1, 1, 1'b0);
      // Burst write across a read-only register, then readback
      q = '{8'hAA, 8'hBB, 8'hCC};
      wr_burst(3, 1'b1, q);
      rd_burst(3, 1'b1, 3, 1'b0);
      // Fixed-address writes: read-only target, then writable target
      q = '{8'h11, 8'h22};
      wr_burst(4, 1'b0, q);
      rd_burst(4, 1'b0, 2, 1'b0);
      q = '{8'h11, 8'h22, 8'h33};
      wr_burst(2, 1'b0, q);
      rd_burst(2, 1'b0, 2, 1'b0);
      // Reading past the end of the bank
      rd_burst(4, 1'b1, 4, 1'b0);

      // Backpressure then clock gate during a two-byte read
      e0 = mread(3); e1 = mread(4);
      push(8'h03); push(8'h82);
      i_bp_ready = 1'b0;
      repeat (3) begin
         @(negedge i_clk);
         check("bp_hold_valid", o_bp_valid, 1);
         check("bp_hold_data", o_bp_data, e0);
         @(posedge i_clk); #1;
      end
      i_cg = 1'b0; i_bp_ready = 1'b1;
      repeat (2) begin
         @(negedge i_clk);
         check("cg_hold_valid", o_bp_valid, 1);
         check("cg_hold_data", o_bp_data, e0);
         @(posedge i_clk); #1;
      end
      i_cg = 1'b1;
      @(negedge i_clk);
      check("cg_rd0", o_bp_data, e0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("cg_rd1_valid", o_bp_valid, 1);
      check("cg_rd1", o_bp_data, e1);
      @(posedge i_clk); #1;
      i_bp_ready = 1'b0;
      @(negedge i_clk);
      check("cg_rd_end", o_bp_valid, 0);
      @(posedge i_clk); #1;
      $display("txn read with backpressure and clock gate");

      // Clock gate during a write: byte is held off until enabled
      push(8'h81); push(8'h81);
      i_cg = 1'b0; i_bp_data = 8'h77; i_bp_valid = 1'b1;
      repeat (2) begin
         @(negedge i_clk);
         check("cg_wr_strobe", o_wrStrobe, 0);
         check("cg_wr_regs", o_regs, flat());
         @(posedge i_clk); #1;
      end
      i_cg = 1'b1;
      push(8'h77);
      m[1] = 8'h77;
      check("cg_wr_done_strobe", o_wrStrobe, 6'b000010);
      check("cg_wr_done_regs", o_regs, flat());
      $display("txn write with clock gate");

      // Reset after two of four write bytes
      push(8'h82); push(8'h84);
      push(8'h12); m[2] = 8'h12;
      push(8'h34); m[3] = 8'h34;
      check("pre_rst_regs", o_regs, flat());
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      model_reset();
      @(negedge i_clk);
      check("midrst_regs", o_regs, flat());
      check("midrst_valid", o_bp_valid, 0);
      check("midrst_ready", o_bp_ready, 1);
      check("midrst_data", o_bp_data, 8'h00);
      @(posedge i_clk); #1;
      $display("txn reset mid-burst");
      q = '{8'h5C};
      wr_burst(5, 1'b1, q);
      rd_burst(0, 1'b1, 6, 1'b0);

      // Length zero: 128 bytes wrapping the address through 127 -> 0
      rd_burst(1, 1'b1, 128, 1'b1);

      for (int t = 0; t < 24; t++) begin
         int a, n;
         bit inc;
         a   = $urandom_range(0, 9);
         n   = $urandom_range(1, 5);
         inc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            q = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            wr_burst(a, inc, q);
         end else begin
            rd_burst(a, inc, n, 1'b1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
